// File: rtl/chan_trig_seq.sv
// Multi-channel level/edge trigger: input synchronisers, per-channel match,
// occurrence counter and a sticky trigger FSM released by capture_done.
module chan_trig_seq #(
    parameter int unsigned NUM_CH      = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  armed,
    input  logic [NUM_CH-1:0]     chL,
    input  logic [NUM_CH-1:0]     chH,
    input  logic [5*NUM_CH-1:0]   ch_cfg,
    input  logic                  prot_trig,
    input  logic [CNT_W-1:0]      trig_cnt,
    input  logic                  capture_done,
    output logic [NUM_CH-1:0]     ch_trig,
    output logic [CNT_W-1:0]      match_cnt,
    output logic                  triggered,
    output logic [1:0]            trig_state
);

    localparam int unsigned CFG_W = 5 * NUM_CH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_TRIG  = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] l_pipe;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] h_pipe;
    logic [NUM_CH-1:0]                  l_prev;
    logic [NUM_CH-1:0]                  h_prev;
    logic [NUM_CH-1:0]                  l_sync;
    logic [NUM_CH-1:0]                  h_sync;
    logic [NUM_CH-1:0]                  match_c;
    logic                               all_match_c;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     match_cnt_d;
    logic                 triggered_d;
    logic [CFG_W-1:0]     cfg_q, cfg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    assign l_sync = l_pipe[SYNC_STAGES-1];
    assign h_sync = h_pipe[SYNC_STAGES-1];

    // Synchroniser chains plus one history stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            l_pipe <= '0;
            h_pipe <= '0;
            l_prev <= '0;
            h_prev <= '0;
        end else begin
            l_pipe <= {l_pipe[SYNC_STAGES-2:0], chL};
            h_pipe <= {h_pipe[SYNC_STAGES-2:0], chH};
            l_prev <= l_sync;
            h_prev <= h_sync;
        end
    end

    // Per-channel condition: OR of the enabled terms of the latched config
    always_comb begin
        match_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            match_c[i] = cfg_q[5*i]
                       | (cfg_q[5*i+1] & ~l_sync[i])
                       | (cfg_q[5*i+2] &  h_sync[i])
                       | (cfg_q[5*i+3] &  l_prev[i] & ~l_sync[i])
                       | (cfg_q[5*i+4] & ~h_prev[i] &  h_sync[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_trig <= '0;
        end else begin
            ch_trig <= match_c;
        end
    end

    assign all_match_c = (&ch_trig) & prot_trig;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            match_cnt <= '0;
            triggered <= 1'b0;
            cfg_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            match_cnt <= match_cnt_d;
            triggered <= triggered_d;
            cfg_q     <= cfg_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state: arm latches config, count qualifying cycles, hold until capture_done
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt;
        triggered_d = triggered;
        cfg_d       = cfg_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                match_cnt_d = '0;
                triggered_d = 1'b0;
                if (armed) begin
                    cfg_d   = ch_cfg;
                    cnt_d   = (trig_cnt == '0) ? CNT_W'(1) : trig_cnt;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!armed) begin
                    match_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else if (all_match_c) begin
                    if ((match_cnt + CNT_W'(1)) == cnt_q) begin
                        match_cnt_d = cnt_q;
                        triggered_d = 1'b1;
                        state_d     = ST_TRIG;
                    end else begin
                        match_cnt_d = match_cnt + CNT_W'(1);
                    end
                end
            end
            ST_TRIG: begin
                triggered_d = 1'b1;
                if (capture_done) begin
                    match_cnt_d = '0;
                    triggered_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                match_cnt_d = '0;
                triggered_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign trig_state = state_q;

endmodule

// File: doc/chan_trig_seq.md
Name: chan_trig_seq

Overview:
- Parametrised successor to the fixed 5-channel logic-analyser channel trigger.
- Supports NUM_CH channels, each with a dual-comparator pair (L/H).
- Per-channel condition is a 5-bit OR of: don't-care, low-level, high-level, negedge, posedge.
- New over the fixed block: configurable input synchroniser depth; config latched at arm time; a match-occurrence counter (fire on the Nth qualifying cycle); a sticky trigger state machine cleared by capture_done.
- Sits between the channel comparator inputs and the capture controller; ANDs with the protocol trigger.

Parameters:
NUM_CH, 5, number of channels (1..16)
SYNC_STAGES, 2, synchroniser flops per CHxL/CHxH input (>=2)
CNT_W, 8, width of the occurrence counter and trig_cnt

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
armed  in  1  capture armed; level
chL  in  NUM_CH  low-comparator outputs, async, bit i = channel i+1
chH  in  NUM_CH  high-comparator outputs, async
ch_cfg  in  5*NUM_CH  per-channel cfg, bits [5i+4:5i] = channel i
prot_trig  in  1  protocol (UART/SPI) trigger qualifier, level
trig_cnt  in  CNT_W  number of matching cycles required; 0 treated as 1
capture_done  in  1  single-cycle pulse from capture controller
ch_trig  out  NUM_CH  registered per-channel match
match_cnt  out  CNT_W  matches counted so far in current arm
triggered  out  1  sticky trigger to capture controller
trig_state  out  2  FSM state: 00 IDLE, 01 COUNT, 10 TRIGGERED

Behaviour:
- Reset: all synchroniser/history flops 0, ch_trig=0, match_cnt=0, triggered=0, trig_state=IDLE, latched cfg/cnt=0.
- Synchroniser: chL/chH pass through SYNC_STAGES flops giving Ls/Hs; one further flop gives previous values Lp/Hp. Edges are compared synchronised-vs-previous only, never on raw inputs.
- Per-channel match (combinational from latched cfg_q), OR of enabled terms:
  - cfg[0] don't-care -> 1
  - cfg[1] low -> ~Ls
  - cfg[2] high -> Hs
  - cfg[3] negedge -> Lp & ~Ls
  - cfg[4] posedge -> ~Hp & Hs
  - cfg==0 -> channel never matches.
- ch_trig[i] registers the match every cycle in every state, so it is observable for debug even when not armed.
- all_match = (&ch_trig) & prot_trig.
- FSM:
  - IDLE: triggered=0, match_cnt=0. When armed=1: latch cfg_q<=ch_cfg, cnt_q<=(trig_cnt==0 ? 1 : trig_cnt), go to COUNT.
  - COUNT: armed=0 -> IDLE with match_cnt cleared. Else if all_match: if match_cnt+1 == cnt_q, go to TRIGGERED, set triggered=1, match_cnt<=cnt_q; else match_cnt<=match_cnt+1. Matches need not be consecutive.
  - TRIGGERED: triggered held 1 regardless of armed, inputs, or cfg changes; match_cnt frozen. capture_done -> IDLE, triggered=0 next cycle.
- Config timing: ch_cfg and trig_cnt changes during COUNT/TRIGGERED have no effect until the next IDLE->COUNT transition.
- capture_done in IDLE or COUNT is ignored.
- Latency: an input transition sampled at rising edge 1 gives ch_trig high after edge SYNC_STAGES+1 and triggered high after edge SYNC_STAGES+2 (cnt_q=1, other channels/prot_trig already matching).
- Priority: rst > capture_done > armed deassert > match increment.
- match_cnt never wraps; COUNT exits at cnt_q, max 2^CNT_W-1.
- rst mid-COUNT or mid-TRIGGERED returns to IDLE next cycle with all outputs at reset values.

Test Plan:
- Level: NUM_CH=5, all cfg=5'h01 except ch1 cfg=5'h02, prot_trig=1, trig_cnt=1, armed=1, chL[0] 1->0 -> ch_trig[0]=1 after edge 3, triggered=1 after edge 4 (SYNC_STAGES=2), trig_state=10.
- Edge: ch2 cfg=5'h10, others 5'h01, chH[1] held 1 from arm -> no trigger; then toggle 0->1 -> single-cycle ch_trig[1] pulse, triggered=1 and remains 1 after chH[1] returns to 0.
- Count: trig_cnt=3, ch1 posedge, three chH[0] pulses spaced 10 cycles apart -> match_cnt 1,2 then triggered on the third; trig_cnt=0 -> fires on the first match.
- Qualifier/cfg: prot_trig=0 with all channels matching -> triggered stays 0; a channel with cfg=0 -> ch_trig bit stays 0 and no trigger.
- Arm/latch: change ch_cfg during COUNT -> old cfg still governs; drop armed at match_cnt=2 -> IDLE, match_cnt=0; capture_done in TRIGGERED -> IDLE next cycle.
- Reset/priority: rst asserted in TRIGGERED -> all outputs 0 next cycle; capture_done coincident with final match in COUNT -> FSM enters TRIGGERED (capture_done ignored outside TRIGGERED).
